// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - single-clock FIFO, any depth, standard or first-word-fall-through read
// Occupancy is tracked by an explicit level counter; full/empty never come from pointer compare.
module sync_fifo_fwft #(
  parameter int BITS      = 32,
  parameter int SIZE      = 16,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = SIZE - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      p_clear,
  input  logic                      p_wr_en,
  input  logic [BITS-1:0]           p_wr_data,
  output logic                      p_wr_full,
  output logic                      p_wr_almost_full,
  input  logic                      p_rd_en,
  output logic [BITS-1:0]           p_rd_data,
  output logic                      p_rd_empty,
  output logic                      p_rd_almost_empty,
  output logic [$clog2(SIZE+1)-1:0] p_level,
  output logic                      p_overflow,
  output logic                      p_underflow
);

  localparam int LW = $clog2(SIZE + 1);
  localparam int PW = $clog2(SIZE);

  logic [BITS-1:0] mem_q [SIZE];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [BITS-1:0] rd_data_q, rd_data_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            full, empty, wa, ra;

  // Explicit wrap so a non-power-of-two depth never addresses entry SIZE.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(SIZE - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (level_q == LW'(SIZE));
  assign empty = (level_q == '0);
  assign wa    = p_wr_en & ~full & ~p_clear;
  assign ra    = p_rd_en & ~empty & ~p_clear;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    rd_data_d = rd_data_q;
    ovf_d     = p_wr_en & full & ~p_clear;
    unf_d     = p_rd_en & empty & ~p_clear;
    if (p_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wa) wr_ptr_d = ptr_next(wr_ptr_q);
      if (ra) begin
        rd_ptr_d  = ptr_next(rd_ptr_q);
        rd_data_d = mem_q[rd_ptr_q];
      end
      case ({wa, ra})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rd_data_q <= rd_data_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wa) mem_q[wr_ptr_q] <= p_wr_data;
  end

  // In FWFT mode the head word is shown live; when empty the last popped word stays stable.
  generate
    if (FWFT != 0) begin : g_fwft
      assign p_rd_data = empty ? rd_data_q : mem_q[rd_ptr_q];
    end else begin : g_std
      assign p_rd_data = rd_data_q;
    end
  endgenerate

  assign p_wr_full         = full;
  assign p_rd_empty        = empty;
  assign p_wr_almost_full  = (int'(level_q) >= AFULL_TH);
  assign p_rd_almost_empty = (int'(level_q) <= AEMPTY_TH);
  assign p_level           = level_q;
  assign p_overflow        = ovf_q;
  assign p_underflow       = unf_q;

endmodule
